// File: rtl/cii_cursor_ctrl.sv
// Cursor and write-strobe controller for the character table RAM.
// Turns accepted key bytes into single-cycle RAM writes and clears rows/screen.
module cii_cursor_ctrl #(
    parameter int          COLS     = 70,
    parameter int          ROWS     = 30,
    parameter logic [7:0]  CLR_CHAR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_vld,
    input  logic [7:0] key_ascii,
    output logic       key_rdy,
    output logic [6:0] char_x_we,
    output logic [4:0] char_y_we,
    output logic [7:0] ascii_we,
    output logic       we_vld,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ADV,
        S_ADV_NONE,
        S_CLR_ROW
    } state_t;

    localparam logic [6:0] LAST_X   = 7'(COLS - 1);
    localparam logic [4:0] LAST_Y   = 5'(ROWS - 1);
    localparam logic [7:0] CLR_END  = 8'(COLS);
    localparam logic [5:0] INIT_END = 6'(ROWS);

    state_t     r_state, w_state_next;
    logic [6:0] r_cx, w_cx_next;
    logic [4:0] r_cy, w_cy_next;
    logic [7:0] r_clr_x, w_clr_x_next;    // one wider than x so COLS marks "row done"
    logic [5:0] r_init_y, w_init_y_next;  // one wider than y so ROWS marks "screen done"
    logic       r_we, w_we_next;
    logic [6:0] r_wx, w_wx_next;
    logic [4:0] r_wy, w_wy_next;
    logic [7:0] r_wd, w_wd_next;

    logic [4:0] w_next_row;
    logic       w_hs;
    logic       w_printable;

    assign w_next_row  = (r_cy == LAST_Y) ? 5'd0 : r_cy + 5'd1;
    assign w_hs        = key_vld && (r_state == S_IDLE);
    assign w_printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_cx     <= 7'd0;
            r_cy     <= 5'd0;
            r_clr_x  <= 8'd0;
            r_init_y <= 6'd0;
            r_we     <= 1'b0;
            r_wx     <= 7'd0;
            r_wy     <= 5'd0;
            r_wd     <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_cx     <= w_cx_next;
            r_cy     <= w_cy_next;
            r_clr_x  <= w_clr_x_next;
            r_init_y <= w_init_y_next;
            r_we     <= w_we_next;
            r_wx     <= w_wx_next;
            r_wy     <= w_wy_next;
            r_wd     <= w_wd_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cx_next     = r_cx;
        w_cy_next     = r_cy;
        w_clr_x_next  = r_clr_x;
        w_init_y_next = r_init_y;
        w_we_next     = 1'b0;
        w_wx_next     = r_wx;
        w_wy_next     = r_wy;
        w_wd_next     = r_wd;
        case (r_state)
            S_INIT: begin
                if (r_init_y == INIT_END) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_we_next = 1'b1;
                    w_wx_next = r_clr_x[6:0];
                    w_wy_next = r_init_y[4:0];
                    w_wd_next = CLR_CHAR;
                    if (r_clr_x[6:0] == LAST_X) begin
                        w_clr_x_next  = 8'd0;
                        w_init_y_next = r_init_y + 6'd1;
                    end else begin
                        w_clr_x_next = r_clr_x + 8'd1;
                    end
                end
            end
            S_IDLE: begin
                if (w_hs) begin
                    if (w_printable) begin
                        w_we_next    = 1'b1;
                        w_wx_next    = r_cx;
                        w_wy_next    = r_cy;
                        w_wd_next    = key_ascii;
                        w_state_next = S_ADV;
                    end else if (key_ascii == 8'h0A || key_ascii == 8'h0D) begin
                        w_cx_next    = 7'd0;
                        w_cy_next    = w_next_row;
                        w_clr_x_next = 8'd0;
                        w_state_next = S_CLR_ROW;
                    end else begin
                        w_state_next = S_ADV_NONE;
                        if (key_ascii == 8'h08) begin
                            // Backspace erases the cell it moves onto; no-op at home.
                            if (r_cx != 7'd0) begin
                                w_cx_next = r_cx - 7'd1;
                                w_we_next = 1'b1;
                                w_wx_next = r_cx - 7'd1;
                                w_wy_next = r_cy;
                                w_wd_next = CLR_CHAR;
                            end else if (r_cy != 5'd0) begin
                                w_cx_next = LAST_X;
                                w_cy_next = r_cy - 5'd1;
                                w_we_next = 1'b1;
                                w_wx_next = LAST_X;
                                w_wy_next = r_cy - 5'd1;
                                w_wd_next = CLR_CHAR;
                            end
                        end
                    end
                end
            end
            S_ADV: begin
                if (r_cx != LAST_X) begin
                    w_cx_next    = r_cx + 7'd1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cx_next    = 7'd0;
                    w_cy_next    = w_next_row;
                    w_clr_x_next = 8'd0;
                    w_state_next = S_CLR_ROW;
                end
            end
            S_ADV_NONE: begin
                w_state_next = S_IDLE;
            end
            S_CLR_ROW: begin
                if (r_clr_x == CLR_END) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_we_next    = 1'b1;
                    w_wx_next    = r_clr_x[6:0];
                    w_wy_next    = r_cy;
                    w_wd_next    = CLR_CHAR;
                    w_clr_x_next = r_clr_x + 8'd1;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    assign key_rdy   = (r_state == S_IDLE);
    assign busy      = (r_state == S_INIT) || (r_state == S_CLR_ROW);
    assign we_vld    = r_we;
    assign char_x_we = r_wx;
    assign char_y_we = r_wy;
    assign ascii_we  = r_wd;
    assign cursor_x  = r_cx;
    assign cursor_y  = r_cy;

endmodule

// File: doc/cii_cursor_ctrl.md
Name: cii_cursor_ctrl

Overview:
Upstream write controller for the character table RAM in the char input interface. It accepts decoded ASCII bytes from the keyboard path through a valid/ready handshake and tracks the text cursor on a COLS x ROWS grid. It turns printable characters, newline and backspace into single-cycle RAM write strobes, clears rows as the cursor enters them, and clears the whole screen after reset.

Parameters:
COLS, 70, characters per row (2..128; write x bus is 7 bits)
ROWS, 30, rows per screen (2..32; write y bus is 5 bits)
CLR_CHAR, 8'h00, code written to clear and erase cells

Ports:
clk  in  1  system clock; everything is on posedge
rst  in  1  asynchronous, active-high reset
key_vld  in  1  key byte valid
key_ascii  in  8  key byte
key_rdy  out  1  controller can accept a byte; equals (state==IDLE)
char_x_we  out  7  RAM write column
char_y_we  out  5  RAM write row
ascii_we  out  8  RAM write data
we_vld  out  1  write strobe; the RAM captures the write on the edge ending the cycle
cursor_x  out  7  current cursor column
cursor_y  out  5  current cursor row
busy  out  1  high in INIT or CLR_ROW

Behaviour:
- Reset (async assert) sets state=INIT, cursor=(0,0), clear counter=0, we_vld=0, char_x_we=0, char_y_we=0, ascii_we=0. key_rdy=0.
- Reset asserted mid-operation aborts immediately. we_vld drops without waiting for a clock. A full INIT runs after release.
- All RAM-side outputs are registered. No dependence on the RAM's we_rdy: the RAM accepts one write every cycle.
- INIT:
  - Exactly COLS*ROWS consecutive cycles of we_vld=1, data CLR_CHAR.
  - Address order is x fastest: (0,0),(1,0)..(COLS-1,0),(0,1)..(COLS-1,ROWS-1).
  - Then IDLE with we_vld=0.
- IDLE: key_rdy=1 and we_vld=0. A handshake is key_vld & key_rdy at a posedge. At that same edge:
  - Printable (0x20..0x7E): we_vld<=1, address<=cursor, ascii_we<=key_ascii, state<=ADV.
  - 0x0A or 0x0D: cursor<=(0, nextrow), clear counter<=0, state<=CLR_ROW. Here nextrow = (cursor_y==ROWS-1) ? 0 : cursor_y+1.
  - 0x08 with cursor_x>0: cursor_x-=1. we_vld<=1 at the new cursor, data CLR_CHAR. state<=ADV_NONE.
  - 0x08 with cursor_x==0 and cursor_y>0: cursor<=(COLS-1, cursor_y-1), then erase as above.
  - 0x08 at (0,0): no write, cursor unchanged, state<=ADV_NONE.
  - Any other code: ignored, state<=ADV_NONE. The byte is consumed.
- ADV (one cycle): we_vld<=0.
  - If cursor_x<COLS-1: cursor_x+=1 and go to IDLE.
  - Else: cursor<=(0, nextrow), clear counter<=0, go to CLR_ROW. Wrap from the last row goes to row 0; there is no scrolling.
- ADV_NONE (one cycle): we_vld<=0, go to IDLE.
- CLR_ROW:
  - Exactly COLS consecutive we_vld=1 cycles at (0..COLS-1, cursor_y), data CLR_CHAR. The first strobe is in the cycle after entry.
  - Then we_vld<=0 and go to IDLE.
  - The cursor stays at (0, cursor_y) throughout.
- Throughput and latency:
  - Printable or backspace: the strobe is visible the cycle after the handshake; key_rdy returns 2 cycles after the handshake.
  - Newline and end-of-row wrap add COLS cycles.
- key_ascii is sampled only at the handshake edge. Changes at other times have no effect.

Test Plan:
- Release reset, hold key_vld=0 -> exactly 2100 strobes with ascii_we=00, last at (69,29); then key_rdy=1, cursor=(0,0).
- After INIT send 'A'(0x41),'B'(0x42) -> writes (0,0)=41 then (1,0)=42; cursor=(2,0); handshake-to-handshake spacing 2 cycles.
- Put the cursor at (69,29) and send 0x5A -> write (69,29)=5A; cursor=(0,0); 70 clear strobes on row 0; busy high during them; then IDLE.
- At (5,3) send 0x0D -> cursor (0,4) and 70 clear strobes on row 4. At (0,4) send 0x08 -> one write (69,3)=00, cursor=(69,3). At (0,0) send 0x08 -> no strobe, cursor stays (0,0).
- Send 0x1B and 0x7F -> no strobe, cursor unchanged, key_rdy high again 2 cycles after each handshake.
- Assert rst during the 30th strobe of a CLR_ROW -> we_vld low before the next edge; after release a full 2100-cycle INIT runs and cursor=(0,0).
